// File: rtl/vend_checkout_ctrl_if.sv
// Pin bundle between the checkout controller and its keypad, voice decoder,
// servo and seven-segment displays.
interface vend_checkout_ctrl_if #(
    parameter int N_COINS  = 3,
    parameter int N_DIGITS = 2
);
    logic [N_COINS:0]      key;
    logic [2:0]            voice;
    logic [3:0]            good;
    logic                  en_duoji;
    logic [1:0]            state_o;
    logic                  ovf;
    logic [7*N_DIGITS-1:0] seg_chg;
    logic [7*N_DIGITS-1:0] seg_item;
    logic [7*N_DIGITS-1:0] seg_pay;

    modport master (
        output key, voice,
        input  good, en_duoji, state_o, ovf, seg_chg, seg_item, seg_pay
    );
    modport slave (
        input  key, voice,
        output good, en_duoji, state_o, ovf, seg_chg, seg_item, seg_pay
    );
endinterface

// File: rtl/vend_checkout_ctrl.sv
// Vending checkout controller: debounced coin/confirm keys, armed voice item
// selection, saturating totals, change computation and dispense sequencing.
module vend_checkout_ctrl #(
    parameter int                   N_COINS         = 3,
    parameter int                   N_DIGITS        = 2,
    parameter logic [8*N_COINS-1:0] COIN_VAL        = {8'd10, 8'd1, 8'd5},
    parameter logic [31:0]          PRICE           = {8'd10, 8'd8, 8'd5, 8'd3},
    parameter int                   DEBOUNCE_CYCLES = 64,
    parameter int                   DISPENSE_CYCLES = 1000,
    parameter int                   HOLD_CYCLES     = 5000
) (
    input logic                 clock,
    input logic                 clr_n,
    vend_checkout_ctrl_if.slave io
);
    localparam int MAX  = 10**N_DIGITS - 1;
    localparam int TW   = $clog2(MAX + 1);
    localparam int NK   = N_COINS + 1;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (DISPENSE_CYCLES > HOLD_CYCLES) ? DISPENSE_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int SW   = TW + 8 + $clog2(NK);
    localparam int SW1  = SW + 1;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOP     = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    // ---------------- key synchronise / debounce ----------------
    logic [NK-1:0] sync1, sync2, sync_prev, db, db_prev, press;
    logic [DW-1:0] deb_cnt [NK];

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            sync1     <= '1;
            sync2     <= '1;
            sync_prev <= '1;
            db        <= '1;
            db_prev   <= '1;
            // NOTE: the counter array is a handful of flops that must start idle, so it is reset like any register.
            for (int i = 0; i < NK; i++) deb_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values, keeping the sync chain a real chain.
            sync1     <= io.key;
            sync2     <= sync1;
            sync_prev <= sync2;
            db_prev   <= db;
            for (int i = 0; i < NK; i++) begin
                if (sync2[i] != sync_prev[i])
                    deb_cnt[i] <= DW'(DEBOUNCE_CYCLES);
                else if (deb_cnt[i] != '0)
                    deb_cnt[i] <= deb_cnt[i] - DW'(1);
                if (sync2[i] == sync_prev[i] && deb_cnt[i] == DW'(1))
                    db[i] <= sync2[i];
            end
        end
    end

    assign press = db_prev & ~db;

    logic [SW-1:0] coin_sum;
    logic          coin_ev, confirm;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        coin_sum = '0;
        for (int i = 0; i < N_COINS; i++)
            if (press[i]) coin_sum = coin_sum + SW'(COIN_VAL[8*i +: 8]);
    end

    assign coin_ev = |press[N_COINS-1:0];
    assign confirm = press[N_COINS];

    // ---------------- voice arm / select ----------------
    logic [2:0] voice_q;
    logic       armed;
    logic       item_ev, cancel_ev;
    logic [1:0] item_idx;

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            voice_q <= '0;
            armed   <= 1'b0;
        end else begin
            voice_q <= io.voice;
            armed   <= (voice_q == 3'b111);  // any other code consumes the arm
        end
    end

    always_comb begin
        item_ev   = 1'b0;
        cancel_ev = 1'b0;
        item_idx  = 2'd0;
        if (armed) begin
            unique case (voice_q)
                3'b001:  begin item_ev = 1'b1; item_idx = 2'd0; end
                3'b010:  begin item_ev = 1'b1; item_idx = 2'd1; end
                3'b100:  begin item_ev = 1'b1; item_idx = 2'd2; end
                3'b011:  begin item_ev = 1'b1; item_idx = 2'd3; end
                3'b000:  cancel_ev = 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- totals and state machine ----------------
    // Returns {saturated, min(a + b, MAX)}.
    function automatic logic [TW:0] sat_add(input logic [TW-1:0] a, input logic [SW-1:0] b);
        logic [SW1-1:0] s;
        s = SW1'(a) + SW1'(b);
        if (s > SW1'(MAX)) return {1'b1, TW'(MAX)};
        return {1'b0, s[TW-1:0]};
    endfunction

    state_t        state, state_nx;
    logic [TW-1:0] item_total, item_nx, pay_total, pay_nx, chg, chg_nx;
    logic [3:0]    good, good_nx;
    logic          ovf_pay, ovf_pay_nx, ovf_item, ovf_item_nx;
    logic [CW-1:0] tmr;
    logic [TW:0]   pay_add, item_add;

    assign pay_add  = sat_add(pay_total, coin_sum);
    assign item_add = sat_add(item_total, SW'(PRICE[8*item_idx +: 8]));

    always_comb begin
        state_nx    = state;
        item_nx     = item_total;
        pay_nx      = pay_total;
        chg_nx      = chg;
        good_nx     = good;
        ovf_pay_nx  = ovf_pay;
        ovf_item_nx = ovf_item;
        unique case (state)
            IDLE, SHOP: begin
                if (state == SHOP && cancel_ev) begin
                    chg_nx   = pay_total;
                    item_nx  = '0;
                    good_nx  = '0;
                    state_nx = CHANGE;
                end else if (state == SHOP && confirm && item_total != '0 && pay_total >= item_total) begin
                    chg_nx   = pay_total - item_total;
                    state_nx = DISPENSE;
                end else begin
                    if (coin_ev) begin
                        pay_nx = pay_add[TW-1:0];
                        if (pay_add[TW]) ovf_pay_nx = 1'b1;
                    end
                    if (item_ev) begin
                        item_nx = item_add[TW-1:0];
                        good_nx = 4'b0001 << item_idx;
                        if (item_add[TW]) ovf_item_nx = 1'b1;
                    end
                    if (coin_ev || item_ev) state_nx = SHOP;
                end
            end
            DISPENSE: if (tmr == CW'(DISPENSE_CYCLES)) state_nx = CHANGE;
            CHANGE: begin
                if (tmr == CW'(HOLD_CYCLES - 1)) begin
                    state_nx    = IDLE;
                    item_nx     = '0;
                    pay_nx      = '0;
                    chg_nx      = '0;
                    good_nx     = '0;
                    ovf_pay_nx  = 1'b0;
                    ovf_item_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            item_total <= '0;
            pay_total  <= '0;
            chg        <= '0;
            good       <= '0;
            ovf_pay    <= 1'b0;
            ovf_item   <= 1'b0;
            tmr        <= '0;
        end else begin
            state      <= state_nx;
            item_total <= item_nx;
            pay_total  <= pay_nx;
            chg        <= chg_nx;
            good       <= good_nx;
            ovf_pay    <= ovf_pay_nx;
            ovf_item   <= ovf_item_nx;
            // Timer restarts on every state entry; it only matters in the timed states.
            if (state_nx != state)
                tmr <= '0;
            else if (state == DISPENSE || state == CHANGE)
                tmr <= tmr + CW'(1);
        end
    end

    // ---------------- displays ----------------
    function automatic logic [6:0] dig7(input logic [3:0] d);
        unique case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_F;
        endcase
    endfunction

    function automatic logic [7*N_DIGITS-1:0] to_seg(input logic [TW-1:0] val, input logic all_f);
        logic [TW-1:0]         v;
        logic [7*N_DIGITS-1:0] seg;
        v   = val;
        seg = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            seg[7*k +: 7] = all_f ? SEG_F : dig7(4'(v % TW'(10)));
            v = v / TW'(10);
        end
        return seg;
    endfunction

    logic [TW-1:0] chg_disp;
    logic          chg_f;

    always_comb begin
        chg_disp = '0;
        chg_f    = 1'b0;
        unique case (state)
            IDLE: ;
            SHOP: begin
                if (pay_total >= item_total) chg_disp = pay_total - item_total;
                else                         chg_f    = 1'b1;
            end
            default: chg_disp = chg;
        endcase
    end

    assign io.seg_chg  = to_seg(chg_disp, chg_f);
    assign io.seg_item = to_seg(item_total, ovf_item);
    assign io.seg_pay  = to_seg(pay_total, ovf_pay);
    assign io.good     = good;
    assign io.ovf      = ovf_pay | ovf_item;
    assign io.state_o  = state;
    // Combinational from registered state, so reset drops the servo without a clock.
    assign io.en_duoji = (state == DISPENSE) && (tmr != '0);
endmodule

// File: tb/tb_vend_checkout_ctrl.sv
// Directed bench for vend_checkout_ctrl with short debounce/dispense/hold timing.
module tb_vend_checkout_ctrl;
    localparam logic [6:0]  SF     = 7'b0001110;
    localparam logic [13:0] SEG_FF = {SF, SF};

    logic clock = 1'b0;
    logic clr_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    vend_checkout_ctrl_if #(.N_COINS(3), .N_DIGITS(2)) io ();

    vend_checkout_ctrl #(
        .N_COINS(3), .N_DIGITS(2),
        .DEBOUNCE_CYCLES(4), .DISPENSE_CYCLES(8), .HOLD_CYCLES(16)
    ) dut (
        .clock(clock),
        .clr_n(clr_n),
        .io   (io)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] segs(input int v);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return {t[v / 10], t[v % 10]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        io.key = ~mask;
        tick(10);
        io.key = '1;
        tick(10);
    endtask

    task automatic say(input logic [2:0] code);
        io.voice = code;
        tick(3);
    endtask

    task automatic wait_state(input string tag, input logic [1:0] target, input int budget);
        for (int i = 0; i < budget && io.state_o != target; i++) tick(1);
        check(tag, 32'(io.state_o), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int high;
        io.key   = '1;
        io.voice = 3'b000;
        tick(3);
        check("rst_state", 32'(io.state_o), 0);
        check("rst_en", 32'(io.en_duoji), 0);
        check("rst_good", 32'(io.good), 0);
        check("rst_ovf", 32'(io.ovf), 0);
        check("rst_seg_chg", 32'(io.seg_chg), 32'(segs(0)));
        check("rst_seg_pay", 32'(io.seg_pay), 32'(segs(0)));
        clr_n = 1'b1;
        tick(2);

        // 1. debounce
        io.key[0] = 1'b0;
        tick(2);
        io.key = '1;
        tick(12);
        check("glitch_pay", 32'(io.seg_pay), 32'(segs(0)));
        check("glitch_state", 32'(io.state_o), 0);
        io.key[0] = 1'b0;
        tick(20);
        check("hold_pay", 32'(io.seg_pay), 32'(segs(5)));
        check("hold_state", 32'(io.state_o), 1);
        io.key = '1;
        tick(12);
        check("release_pay", 32'(io.seg_pay), 32'(segs(5)));

        // 2. voice handshake
        say(3'b111); say(3'b001); say(3'b001);
        check("voice_item3", 32'(io.seg_item), 32'(segs(3)));
        check("voice_good1", 32'(io.good), 32'h1);
        say(3'b111); say(3'b011);
        check("voice_item13", 32'(io.seg_item), 32'(segs(13)));
        check("voice_good8", 32'(io.good), 32'h8);
        check("voice_chg_ff", 32'(io.seg_chg), 32'(SEG_FF));
        say(3'b111); say(3'b000);
        check("cancel1_state", 32'(io.state_o), 3);
        check("cancel1_chg", 32'(io.seg_chg), 32'(segs(5)));
        wait_state("cancel1_idle", 2'd0, 30);

        // 3. checkout
        say(3'b111); say(3'b100);
        check("co_item8", 32'(io.seg_item), 32'(segs(8)));
        check("co_good4", 32'(io.good), 32'h4);
        press(4'b0001); press(4'b0001); press(4'b0010);
        check("co_pay11", 32'(io.seg_pay), 32'(segs(11)));
        check("co_chg_shop", 32'(io.seg_chg), 32'(segs(3)));
        io.key[3] = 1'b0;
        wait_state("co_enter_disp", 2'd2, 30);
        check("co_en_entry", 32'(io.en_duoji), 0);
        check("co_chg_disp", 32'(io.seg_chg), 32'(segs(3)));
        high = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (io.state_o != 2'd2) break;
            if (io.en_duoji) high++;
        end
        io.key = '1;
        check("co_en_cycles", 32'(high), 8);
        check("co_change_state", 32'(io.state_o), 3);
        check("co_chg_hold", 32'(io.seg_chg), 32'(segs(3)));
        check("co_en_after", 32'(io.en_duoji), 0);
        tick(16);
        check("co_idle", 32'(io.state_o), 0);
        check("co_clr_pay", 32'(io.seg_pay), 32'(segs(0)));
        check("co_clr_item", 32'(io.seg_item), 32'(segs(0)));
        check("co_clr_chg", 32'(io.seg_chg), 32'(segs(0)));
        check("co_clr_good", 32'(io.good), 0);

        // 4. insufficient payment
        say(3'b111); say(3'b011);
        press(4'b0001); press(4'b0010);
        check("ins_pay6", 32'(io.seg_pay), 32'(segs(6)));
        press(4'b1000);
        check("ins_state", 32'(io.state_o), 1);
        check("ins_chg_ff", 32'(io.seg_chg), 32'(SEG_FF));
        check("ins_en", 32'(io.en_duoji), 0);
        say(3'b111); say(3'b000);
        wait_state("ins_idle", 2'd0, 30);

        // 5. cancel / refund
        press(4'b0100); press(4'b0010);
        say(3'b111); say(3'b010);
        check("can_item5", 32'(io.seg_item), 32'(segs(5)));
        say(3'b111); say(3'b000);
        check("can_state", 32'(io.state_o), 3);
        check("can_chg11", 32'(io.seg_chg), 32'(segs(11)));
        check("can_item0", 32'(io.seg_item), 32'(segs(0)));
        wait_state("can_idle", 2'd0, 30);

        // 6. saturation, simultaneous coins, reset during dispense
        for (int i = 0; i < 9; i++) press(4'b0100);
        check("sat_pay90", 32'(io.seg_pay), 32'(segs(90)));
        check("sat_ovf0", 32'(io.ovf), 0);
        press(4'b0100);
        check("sat_ovf1", 32'(io.ovf), 1);
        check("sat_seg_ff", 32'(io.seg_pay), 32'(SEG_FF));
        say(3'b111); say(3'b000);
        check("sat_refund", 32'(io.seg_chg), 32'(segs(99)));
        wait_state("sat_idle", 2'd0, 30);
        check("sat_ovf_clr", 32'(io.ovf), 0);
        press(4'b0011);
        check("dual_pay6", 32'(io.seg_pay), 32'(segs(6)));
        say(3'b111); say(3'b001);
        io.key[3] = 1'b0;
        wait_state("rst_enter_disp", 2'd2, 30);
        tick(3);
        check("rst_en_high", 32'(io.en_duoji), 1);
        clr_n = 1'b0;
        #1;
        check("rst_en_drop", 32'(io.en_duoji), 0);
        check("rst_mid_state", 32'(io.state_o), 0);
        check("rst_mid_chg", 32'(io.seg_chg), 32'(segs(0)));
        check("rst_mid_item", 32'(io.seg_item), 32'(segs(0)));
        check("rst_mid_pay", 32'(io.seg_pay), 32'(segs(0)));
        io.key = '1;
        tick(2);
        clr_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
